// File: rtl/branch_resolve_predict.sv
// Branch resolution unit with a bimodal branch-history-table predictor.
// Resolves conditional branches one cycle after request, trains a table of
// saturating counters on accepted resolves, and keeps branch/mispredict stats.
module branch_resolve_predict #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int PC_LSB    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_taken,
  input  logic            resolve_valid,
  input  logic            branch,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            resolve_pred,
  output logic            resolve_done,
  output logic            take_branch,
  output logic            mispredict,
  output logic            illegal_f3,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] bht [BHT_DEPTH];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic             is_illegal;
  logic             taken;
  logic             resolve_req;
  logic             accept;
  logic             is_mispredict;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;

  // Only the index field of each PC is meaningful; fold the rest into a sink.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, resolve_pc};

  assign lookup_idx  = lookup_pc[PC_LSB +: IDX_W];
  assign resolve_idx = resolve_pc[PC_LSB +: IDX_W];

  // Prediction reads the table before any same-edge update lands.
  always_comb begin
    predict_taken = bht[lookup_idx][CNT_W-1];
  end

  // Branch condition evaluation over the full operand width.
  always_comb begin
    is_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
    taken      = 1'b0;
    case (funct3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Request qualification and saturating counter step.
  always_comb begin
    resolve_req   = resolve_valid & branch;
    accept        = resolve_req & ~is_illegal;
    is_mispredict = taken ^ resolve_pred;
    cnt_cur       = bht[resolve_idx];
    cnt_next      = cnt_cur;
    if (taken) begin
      if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - 1'b1;
    end
  end

  // Table training: every accepted resolve writes its own index, so
  // back-to-back updates to one entry chain through the stored value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (accept) begin
      bht[resolve_idx] <= cnt_next;
    end
  end

  // Registered resolve result; outcome flags are gated to accepted requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resolve_done <= 1'b0;
      take_branch  <= 1'b0;
      mispredict   <= 1'b0;
      illegal_f3   <= 1'b0;
    end else begin
      resolve_done <= resolve_req;
      illegal_f3   <= resolve_req & is_illegal;
      take_branch  <= accept & taken;
      mispredict   <= accept & is_mispredict;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (accept) begin
      if (branch_count != '1) branch_count <= branch_count + 32'd1;
      if (is_mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict with a behavioural reference model.
module tb_branch_resolve_predict;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 2;
  localparam int PC_LSB = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] lookup_pc = '0;
  logic            predict_taken;
  logic            resolve_valid = 1'b0;
  logic            branch = 1'b0;
  logic [XLEN-1:0] resolve_pc = '0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic            resolve_pred = 1'b0;
  logic            resolve_done;
  logic            take_branch;
  logic            mispredict;
  logic            illegal_f3;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  branch_resolve_predict #(
    .XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W), .PC_LSB(PC_LSB)
  ) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .branch(branch), .resolve_pc(resolve_pc),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .resolve_pred(resolve_pred),
    .resolve_done(resolve_done), .take_branch(take_branch), .mispredict(mispredict),
    .illegal_f3(illegal_f3), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mcnt [DEPTH];
  longint      m_bcnt;
  longint      m_mcnt;
  logic        e_done, e_take, e_mis, e_ill;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc >> PC_LSB) % DEPTH);
  endfunction

  function automatic bit outcome(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_pred(input logic [XLEN-1:0] pc);
    return mcnt[idx_of(pc)] >= (1 << (CNT_W - 1));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mcnt[i] = (1 << (CNT_W - 1)) - 1;
    m_bcnt = 0;
    m_mcnt = 0;
    e_done = 1'b0; e_take = 1'b0; e_mis = 1'b0; e_ill = 1'b0;
  endfunction

  // Model advance on each clock edge, from the inputs present at the edge.
  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      bit req, ill, t;
      int i;
      req = resolve_valid && branch;
      ill = (funct3 == 3'd2) || (funct3 == 3'd3);
      e_done = req;
      e_ill  = req && ill;
      e_take = 1'b0;
      e_mis  = 1'b0;
      if (req && !ill) begin
        t = outcome(funct3, rs1_val, rs2_val);
        i = idx_of(resolve_pc);
        e_take = t;
        e_mis  = (t != resolve_pred);
        if (t) mcnt[i] = (mcnt[i] == (1 << CNT_W) - 1) ? mcnt[i] : mcnt[i] + 1;
        else   mcnt[i] = (mcnt[i] == 0) ? 0 : mcnt[i] - 1;
        if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
        if (e_mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
      end
    end
  end

  always @(posedge reset) model_reset();

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    chk("resolve_done", resolve_done, e_done);
    chk("take_branch", take_branch, e_take);
    chk("mispredict", mispredict, e_mis);
    chk("illegal_f3", illegal_f3, e_ill);
    chk("branch_count", branch_count, m_bcnt);
    chk("mispredict_count", mispredict_count, m_mcnt);
    chk("predict_taken", predict_taken, model_pred(lookup_pc));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rv, input logic br, input logic [XLEN-1:0] pc,
                       input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic pred);
    resolve_valid = rv; branch = br; resolve_pc = pc; funct3 = f3;
    rs1_val = a; rs2_val = b; resolve_pred = pred;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 3'd0, '0, '0, 1'b0);
  endtask

  logic [XLEN-1:0] opa [4];
  logic [XLEN-1:0] opb [4];

  initial begin
    model_reset();
    lookup_pc = 32'h100;
    tick();
    tick();
    reset = 1'b0;
    #1;
    // Post-reset state
    chk("rst_pred_0x100", predict_taken, 1'b0);
    chk("rst_bcnt", branch_count, 0);
    chk("rst_mcnt", mispredict_count, 0);
    chk("rst_done", resolve_done, 1'b0);

    // BEQ at 0x100, equal operands, predicted not-taken
    drive(1'b1, 1'b1, 32'h100, 3'd0, 32'd5, 32'd5, 1'b0);
    chk("beq_pre_pred", predict_taken, 1'b0);
    tick();
    idle();
    chk("beq_done", resolve_done, 1'b1);
    chk("beq_take", take_branch, 1'b1);
    chk("beq_mis", mispredict, 1'b1);
    chk("beq_mcnt", mispredict_count, 1);
    chk("beq_post_pred", predict_taken, 1'b1);
    tick();
    chk("beq_done_one_cycle", resolve_done, 1'b0);

    // BLT vs BLTU with the same operands, back to back
    drive(1'b1, 1'b1, 32'h204, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 32'h208, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("blt_take", take_branch, 1'b1);
    chk("blt_mis", mispredict, 1'b0);
    tick();
    idle();
    chk("bltu_take", take_branch, 1'b0);
    chk("bltu_mis", mispredict, 1'b1);
    chk("bltu_bcnt", branch_count, 3);
    chk("bltu_mcnt", mispredict_count, 2);

    // Counter training at 0x40: four taken then two not-taken, back to back
    lookup_pc = 32'h40;
    drive(1'b1, 1'b1, 32'h40, 3'd0, 32'd7, 32'd7, 1'b1);
    chk("train_first_pre", predict_taken, 1'b0);
    tick();
    chk("train_after1", predict_taken, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    drive(1'b1, 1'b1, 32'h40, 3'd1, 32'd7, 32'd7, 1'b1);
    chk("train_sat", predict_taken, 1'b1);
    tick();
    chk("train_dec_once", predict_taken, 1'b1);
    tick();
    idle();
    chk("train_dec_twice", predict_taken, 1'b0);
    chk("train_bcnt", branch_count, 9);
    chk("train_mcnt", mispredict_count, 4);

    // Saturation at zero at 0x10
    lookup_pc = 32'h10;
    drive(1'b1, 1'b1, 32'h10, 3'd5, 32'd1, 32'd2, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b1, 32'h10, 3'd7, 32'd2, 32'd1, 1'b0);
    tick();
    idle();
    chk("sat0_pred", predict_taken, 1'b0);

    // Non-branch request is ignored
    drive(1'b1, 1'b0, 32'h40, 3'd0, 32'd1, 32'd1, 1'b0);
    tick();
    idle();
    chk("nonbr_done", resolve_done, 1'b0);
    chk("nonbr_bcnt", branch_count, 12);

    // Illegal funct3 values
    drive(1'b1, 1'b1, 32'h40, 3'd2, 32'd1, 32'd1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h40, 3'd3, 32'd1, 32'd1, 1'b0);
    chk("ill2_done", resolve_done, 1'b1);
    chk("ill2_flag", illegal_f3, 1'b1);
    chk("ill2_take", take_branch, 1'b0);
    tick();
    idle();
    chk("ill3_flag", illegal_f3, 1'b1);
    chk("ill_bcnt", branch_count, 12);
    chk("ill_mcnt", mispredict_count, 5);

    // Sweep every funct3 over a few operand pairs
    opa[0] = 32'd5;          opb[0] = 32'd5;
    opa[1] = 32'd3;          opb[1] = 32'd7;
    opa[2] = 32'h8000_0000;  opb[2] = 32'd1;
    opa[3] = 32'd7;          opb[3] = 32'd3;
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 4; p++) begin
        lookup_pc = 32'(p * 4 + 32'h300);
        drive(1'b1, 1'b1, 32'(p * 4 + 32'h300), 3'(f), opa[p], opb[p], 1'(p & 1));
        tick();
      end
    end
    idle();
    tick();

    // Reset asserted right after an accepted resolve
    lookup_pc = 32'h80;
    drive(1'b1, 1'b1, 32'h80, 3'd0, 32'd9, 32'd9, 1'b0);
    tick();
    idle();
    chk("pre_rst_done", resolve_done, 1'b1);
    chk("pre_rst_pred", predict_taken, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_now_done", resolve_done, 1'b0);
    chk("rst_now_take", take_branch, 1'b0);
    chk("rst_now_mis", mispredict, 1'b0);
    chk("rst_now_bcnt", branch_count, 0);
    chk("rst_now_mcnt", mispredict_count, 0);
    chk("rst_now_pred", predict_taken, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_after_done", resolve_done, 1'b0);

    // Reset asserted while a resolve is pending at the next edge
    drive(1'b1, 1'b1, 32'h80, 3'd0, 32'd9, 32'd9, 1'b0);
    reset = 1'b1;
    tick();
    idle();
    reset = 1'b0;
    tick();
    chk("inflight_done", resolve_done, 1'b0);
    chk("inflight_pred", predict_taken, 1'b0);
    chk("inflight_bcnt", branch_count, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
